// File: rtl/rf_commit_ctrl.sv
// In-order commit sequencer: retires at most one ROB head entry per cycle into RF / LSB / flush.
// Latency: pop decision is combinational in cycle N; RF write, store request and flush appear at N+1.
// Backpressure: en=0 freezes all state (rf_en_o drops); a store holds the head until en & st_ack_i.
module rf_commit_ctrl #(
  parameter int REG_BIT   = 5,
  parameter int ROB_BIT   = 4,
  parameter int DAT_W     = 32,
  parameter int FLUSH_CYC = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               head_valid_i,
  input  logic               head_ready_i,
  input  logic [ROB_BIT-1:0] head_id_i,
  input  logic [1:0]         head_kind_i,
  input  logic [REG_BIT-1:0] head_rd_i,
  input  logic [DAT_W-1:0]   head_v_i,
  input  logic               head_mispred_i,
  input  logic [DAT_W-1:0]   head_target_i,
  input  logic               st_ack_i,
  output logic               rob_pop_o,
  output logic               rf_en_o,
  output logic [REG_BIT-1:0] rf_rd_o,
  output logic [ROB_BIT-1:0] rf_q_o,
  output logic [DAT_W-1:0]   rf_v_o,
  output logic               st_req_o,
  output logic [ROB_BIT-1:0] st_rob_o,
  output logic               flush_o,
  output logic [DAT_W-1:0]   flush_pc_o,
  output logic [31:0]        retire_cnt_o
);

  // Flush counter holds FLUSH_CYC-1 down to 0; keep at least one bit.
  localparam int CNT_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    ST_WAIT = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  localparam logic [1:0] KIND_STORE  = 2'd1;
  localparam logic [1:0] KIND_BRANCH = 2'd2;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               commit;
  logic               is_store;
  logic               is_branch;

  logic               rf_en_nxt;
  logic [REG_BIT-1:0] rf_rd_nxt;
  logic [ROB_BIT-1:0] rf_q_nxt;
  logic [DAT_W-1:0]   rf_v_nxt;
  logic               st_req_nxt;
  logic [ROB_BIT-1:0] st_rob_nxt;
  logic               flush_nxt;
  logic [DAT_W-1:0]   flush_pc_nxt;
  logic [31:0]        retire_nxt;

  // Reserved kind 3 falls through as a plain register write.
  assign commit    = en & head_valid_i & head_ready_i;
  assign is_store  = (head_kind_i == KIND_STORE);
  assign is_branch = (head_kind_i == KIND_BRANCH);

  // Next-state, combinational pop and next values of every registered output.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    rob_pop_o    = 1'b0;
    rf_en_nxt    = 1'b0;
    rf_rd_nxt    = rf_rd_o;
    rf_q_nxt     = rf_q_o;
    rf_v_nxt     = rf_v_o;
    st_req_nxt   = st_req_o;
    st_rob_nxt   = st_rob_o;
    flush_nxt    = flush_o;
    flush_pc_nxt = flush_pc_o;
    retire_nxt   = retire_cnt_o;

    if (en) begin
      case (state)
        RUN: begin
          if (commit) begin
            if (is_store) begin
              // Store waits for the LSB; the head stays put until acked.
              st_req_nxt = 1'b1;
              st_rob_nxt = head_id_i;
              state_nxt  = ST_WAIT;
            end else begin
              rob_pop_o  = 1'b1;
              rf_en_nxt  = (head_rd_i != '0);
              rf_rd_nxt  = head_rd_i;
              rf_q_nxt   = head_id_i;
              rf_v_nxt   = head_v_i;
              retire_nxt = retire_cnt_o + 32'd1;
              if (is_branch && head_mispred_i) begin
                flush_nxt    = 1'b1;
                flush_pc_nxt = head_target_i;
                cnt_nxt      = CNT_W'(FLUSH_CYC - 1);
                state_nxt    = FLUSH;
              end
            end
          end
        end

        ST_WAIT: begin
          if (st_ack_i) begin
            rob_pop_o  = 1'b1;
            st_req_nxt = 1'b0;
            retire_nxt = retire_cnt_o + 32'd1;
            state_nxt  = RUN;
          end
        end

        FLUSH: begin
          if (cnt == '0) begin
            flush_nxt = 1'b0;
            state_nxt = RUN;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end

        default: begin
          state_nxt = RUN;
        end
      endcase
    end

    // Reset wins: nothing leaves the ROB while it is held.
    if (rst) begin
      rob_pop_o = 1'b0;
    end
  end

  // State register and registered outputs, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      cnt          <= '0;
      rf_en_o      <= 1'b0;
      rf_rd_o      <= '0;
      rf_q_o       <= '0;
      rf_v_o       <= '0;
      st_req_o     <= 1'b0;
      st_rob_o     <= '0;
      flush_o      <= 1'b0;
      flush_pc_o   <= '0;
      retire_cnt_o <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      rf_en_o      <= rf_en_nxt;
      rf_rd_o      <= rf_rd_nxt;
      rf_q_o       <= rf_q_nxt;
      rf_v_o       <= rf_v_nxt;
      st_req_o     <= st_req_nxt;
      st_rob_o     <= st_rob_nxt;
      flush_o      <= flush_nxt;
      flush_pc_o   <= flush_pc_nxt;
      retire_cnt_o <= retire_nxt;
    end
  end

  // A pop must never happen while stalled or in reset.
  pop_gated: assert property (@(posedge clk) rob_pop_o |-> (en && !rst));

  // A pending store and a flush are mutually exclusive phases.
  st_flush_excl: assert property (@(posedge clk) !(st_req_o && flush_o));

endmodule

// File: tb/tb_rf_commit_ctrl.sv
module tb_rf_commit_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        head_valid_i;
  logic        head_ready_i;
  logic [3:0]  head_id_i;
  logic [1:0]  head_kind_i;
  logic [4:0]  head_rd_i;
  logic [31:0] head_v_i;
  logic        head_mispred_i;
  logic [31:0] head_target_i;
  logic        st_ack_i;
  logic        rob_pop_o;
  logic        rf_en_o;
  logic [4:0]  rf_rd_o;
  logic [3:0]  rf_q_o;
  logic [31:0] rf_v_o;
  logic        st_req_o;
  logic [3:0]  st_rob_o;
  logic        flush_o;
  logic [31:0] flush_pc_o;
  logic [31:0] retire_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [3:0]  q;
    logic [31:0] v;
  } rf_exp_t;

  rf_exp_t sb[$];

  always #5 clk = ~clk;

  rf_commit_ctrl #(
    .REG_BIT(5), .ROB_BIT(4), .DAT_W(32), .FLUSH_CYC(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .head_valid_i(head_valid_i), .head_ready_i(head_ready_i),
    .head_id_i(head_id_i), .head_kind_i(head_kind_i), .head_rd_i(head_rd_i),
    .head_v_i(head_v_i), .head_mispred_i(head_mispred_i),
    .head_target_i(head_target_i), .st_ack_i(st_ack_i),
    .rob_pop_o(rob_pop_o), .rf_en_o(rf_en_o), .rf_rd_o(rf_rd_o),
    .rf_q_o(rf_q_o), .rf_v_o(rf_v_o), .st_req_o(st_req_o),
    .st_rob_o(st_rob_o), .flush_o(flush_o), .flush_pc_o(flush_pc_o),
    .retire_cnt_o(retire_cnt_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One cycle: apply inputs at negedge, check the combinational pop, record expected RF write.
  task automatic drive(input string tag, input logic r, input logic e,
                       input logic vld, input logic rdy, input logic [3:0] id,
                       input logic [1:0] kind, input logic [4:0] rd, input logic [31:0] v,
                       input logic mis, input logic [31:0] tgt, input logic ack,
                       input logic exp_pop);
    rf_exp_t item;
    @(negedge clk);
    rst = r; en = e; head_valid_i = vld; head_ready_i = rdy; head_id_i = id;
    head_kind_i = kind; head_rd_i = rd; head_v_i = v; head_mispred_i = mis;
    head_target_i = tgt; st_ack_i = ack;
    #1;
    check_eq($sformatf("%s_pop", tag), {31'd0, rob_pop_o}, {31'd0, exp_pop});
    if (exp_pop && kind != 2'd1 && rd != 5'd0) begin
      item.rd = rd; item.q = id; item.v = v;
      sb.push_back(item);
    end
  endtask

  task automatic idle(input string tag);
    drive(tag, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq($sformatf("%s_rf_en", tag), {31'd0, rf_en_o}, 32'd0);
    check_eq($sformatf("%s_rf_rd", tag), {27'd0, rf_rd_o}, 32'd0);
    check_eq($sformatf("%s_rf_q", tag), {28'd0, rf_q_o}, 32'd0);
    check_eq($sformatf("%s_rf_v", tag), rf_v_o, 32'd0);
    check_eq($sformatf("%s_st_req", tag), {31'd0, st_req_o}, 32'd0);
    check_eq($sformatf("%s_st_rob", tag), {28'd0, st_rob_o}, 32'd0);
    check_eq($sformatf("%s_flush", tag), {31'd0, flush_o}, 32'd0);
    check_eq($sformatf("%s_flush_pc", tag), flush_pc_o, 32'd0);
    check_eq($sformatf("%s_retire", tag), retire_cnt_o, 32'd0);
  endtask

  // RF write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    rf_exp_t e;
    if (rf_en_o === 1'b1) begin
      if (sb.size() == 0) begin
        check_eq("rf_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("rf_rd", {27'd0, rf_rd_o}, {27'd0, e.rd});
        check_eq("rf_q", {28'd0, rf_q_o}, {28'd0, e.q});
        check_eq("rf_v", rf_v_o, e.v);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; head_valid_i = 1'b0; head_ready_i = 1'b0; head_id_i = '0;
    head_kind_i = '0; head_rd_i = '0; head_v_i = '0; head_mispred_i = 1'b0;
    head_target_i = '0; st_ack_i = 1'b0;

    // Reset held with a ready head: no pop
    drive("rst_a", 1, 1, 1, 1, 4'd3, 2'd0, 5'd5, 32'h1234, 0, 0, 0, 0);
    drive("rst_b", 1, 1, 1, 1, 4'd3, 2'd0, 5'd5, 32'h1234, 0, 0, 0, 0);

    // Three back-to-back register commits
    drive("wr_a", 0, 1, 1, 1, 4'd3, 2'd0, 5'd5, 32'h1234, 0, 0, 0, 1);
    check_all_zero("reset");
    drive("wr_b", 0, 1, 1, 1, 4'd4, 2'd0, 5'd5, 32'h1234, 0, 0, 0, 1);
    check_eq("wr_b_rf_en", {31'd0, rf_en_o}, 32'd1);
    drive("wr_c", 0, 1, 1, 1, 4'd5, 2'd0, 5'd5, 32'h1234, 0, 0, 0, 1);
    check_eq("wr_c_rf_en", {31'd0, rf_en_o}, 32'd1);
    idle("idle1");
    check_eq("wr_retire", retire_cnt_o, 32'd3);
    check_eq("wr_last_rf_en", {31'd0, rf_en_o}, 32'd1);

    // rd=0: pops and counts, no RF strobe
    drive("rd0", 0, 1, 1, 1, 4'd6, 2'd0, 5'd0, 32'hFFFF, 0, 0, 0, 1);
    idle("idle2");
    check_eq("rd0_rf_en", {31'd0, rf_en_o}, 32'd0);
    check_eq("rd0_retire", retire_cnt_o, 32'd4);

    // Reserved kind behaves as a register write
    drive("k3", 0, 1, 1, 1, 4'd15, 2'd3, 5'd6, 32'hABCD, 0, 0, 0, 1);
    idle("idle3");
    check_eq("k3_retire", retire_cnt_o, 32'd5);

    // Stall in RUN with a ready head
    drive("en0_run", 0, 0, 1, 1, 4'd2, 2'd0, 5'd7, 32'h77, 0, 0, 0, 0);
    idle("idle4");
    check_eq("en0_retire", retire_cnt_o, 32'd5);
    check_eq("en0_rf_en", {31'd0, rf_en_o}, 32'd0);

    // Store with ack after 3 request cycles
    drive("st_s", 0, 1, 1, 1, 4'd7, 2'd1, 5'd0, 32'd0, 0, 0, 0, 0);
    drive("st_w1", 0, 1, 1, 1, 4'd7, 2'd1, 5'd0, 32'd0, 0, 0, 0, 0);
    check_eq("st_w1_req", {31'd0, st_req_o}, 32'd1);
    check_eq("st_w1_rob", {28'd0, st_rob_o}, 32'd7);
    drive("st_w2", 0, 1, 1, 1, 4'd7, 2'd1, 5'd0, 32'd0, 0, 0, 0, 0);
    check_eq("st_w2_req", {31'd0, st_req_o}, 32'd1);
    drive("st_w3", 0, 1, 1, 1, 4'd7, 2'd1, 5'd0, 32'd0, 0, 0, 1, 1);
    check_eq("st_w3_req", {31'd0, st_req_o}, 32'd1);
    idle("idle5");
    check_eq("st_done_req", {31'd0, st_req_o}, 32'd0);
    check_eq("st_done_rf_en", {31'd0, rf_en_o}, 32'd0);
    check_eq("st_retire", retire_cnt_o, 32'd6);

    // Mispredicted jump with link write, ready head held off during flush
    drive("mp", 0, 1, 1, 1, 4'd8, 2'd2, 5'd1, 32'h100, 1, 32'h2000, 0, 1);
    drive("fl1", 0, 1, 1, 1, 4'd9, 2'd0, 5'd2, 32'h55, 0, 0, 0, 0);
    check_eq("fl1_flush", {31'd0, flush_o}, 32'd1);
    check_eq("fl1_pc", flush_pc_o, 32'h2000);
    check_eq("mp_retire", retire_cnt_o, 32'd7);
    drive("fl2", 0, 1, 1, 1, 4'd9, 2'd0, 5'd2, 32'h55, 0, 0, 0, 0);
    check_eq("fl2_flush", {31'd0, flush_o}, 32'd1);
    drive("fl3", 0, 1, 1, 1, 4'd9, 2'd0, 5'd2, 32'h55, 0, 0, 0, 1);
    check_eq("fl3_flush", {31'd0, flush_o}, 32'd0);
    idle("idle6");
    check_eq("fl_retire", retire_cnt_o, 32'd8);

    // Stall mid-store with ack already high
    drive("st2_s", 0, 1, 1, 1, 4'd10, 2'd1, 5'd0, 32'd0, 0, 0, 0, 0);
    drive("st2_e0a", 0, 0, 1, 1, 4'd10, 2'd1, 5'd0, 32'd0, 0, 0, 1, 0);
    drive("st2_e0b", 0, 0, 1, 1, 4'd10, 2'd1, 5'd0, 32'd0, 0, 0, 1, 0);
    check_eq("st2_hold_req", {31'd0, st_req_o}, 32'd1);
    check_eq("st2_hold_rob", {28'd0, st_rob_o}, 32'd10);
    drive("st2_e1", 0, 1, 1, 1, 4'd10, 2'd1, 5'd0, 32'd0, 0, 0, 1, 1);
    idle("idle7");
    check_eq("st2_done_req", {31'd0, st_req_o}, 32'd0);
    check_eq("st2_retire", retire_cnt_o, 32'd9);

    // Reset during FLUSH
    drive("mp2", 0, 1, 1, 1, 4'd11, 2'd2, 5'd0, 32'd0, 1, 32'h3000, 0, 1);
    drive("rstf", 1, 1, 1, 1, 4'd12, 2'd0, 5'd3, 32'h77, 0, 0, 0, 0);
    check_eq("rstf_flush", {31'd0, flush_o}, 32'd1);
    check_eq("rstf_pc", flush_pc_o, 32'h3000);
    drive("post_rstf", 0, 1, 1, 1, 4'd12, 2'd0, 5'd3, 32'h77, 0, 0, 0, 1);
    check_all_zero("rst_flush");
    idle("idle8");
    check_eq("post_rstf_retire", retire_cnt_o, 32'd1);

    // Reset during ST_WAIT abandons the store
    drive("st3_s", 0, 1, 1, 1, 4'd13, 2'd1, 5'd0, 32'd0, 0, 0, 0, 0);
    drive("st3_w1", 0, 1, 1, 1, 4'd13, 2'd1, 5'd0, 32'd0, 0, 0, 0, 0);
    check_eq("st3_req", {31'd0, st_req_o}, 32'd1);
    check_eq("st3_rob", {28'd0, st_rob_o}, 32'd13);
    drive("rsts", 1, 1, 1, 1, 4'd13, 2'd1, 5'd0, 32'd0, 0, 0, 1, 0);
    drive("post_rsts", 0, 1, 1, 1, 4'd14, 2'd0, 5'd4, 32'h99, 0, 0, 0, 1);
    check_all_zero("rst_store");
    idle("idle9");
    check_eq("post_rsts_retire", retire_cnt_o, 32'd1);
    idle("idle10");

    check_eq("sb_drain", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rf_commit_ctrl.md
# rf_commit_ctrl

In-order commit sequencer between the ROB head and the register file. Each cycle it inspects the ROB head entry and retires at most one instruction. Register results go to the register-file write port, stores are handed to the load/store buffer with a req/ack handshake, and a mispredicted branch raises a multi-cycle flush. It is the only block that drives the register-file write/clear port, so architectural state changes only at commit.

## Interface
- REG_BIT, 5: register index width
- ROB_BIT, 4: ROB entry id width
- DAT_W, 32: data/PC width
- FLUSH_CYC, 2: cycles flush_o stays high per mispredict (≥1)

- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high; priority over en
- en  in  1  global enable/stall
- head_valid_i  in  1  ROB head entry occupied
- head_ready_i  in  1  head result available
- head_id_i  in  ROB_BIT  head ROB id
- head_kind_i  in  2  0=reg write, 1=store, 2=branch/jump, 3=reserved (treated as 0)
- head_rd_i  in  REG_BIT  destination register
- head_v_i  in  DAT_W  result value (link address for jumps)
- head_mispred_i  in  1  branch resolved mispredicted
- head_target_i  in  DAT_W  correct PC for mispredict
- st_ack_i  in  1  LSB accepted store
- rob_pop_o  out  1  combinational; ROB advances head at this edge
- rf_en_o  out  1  register-file write strobe
- rf_rd_o  out  REG_BIT  write register
- rf_q_o  out  ROB_BIT  committing ROB id (RF clears rename tag if it matches)
- rf_v_o  out  DAT_W  write value
- st_req_o  out  1  store commit request
- st_rob_o  out  ROB_BIT  ROB id of requested store
- flush_o  out  1  pipeline flush
- flush_pc_o  out  DAT_W  redirect PC
- retire_cnt_o  out  32  retired-instruction counter, wraps

## Operation
- States: RUN, ST_WAIT, FLUSH. Reset state is RUN.
- commit = en & head_valid_i & head_ready_i.
- RUN, commit, kind 0/3/2 not mispredicted:
  - rob_pop_o=1.
  - Next edge: rf_en_o=(head_rd_i≠0), rf_rd_o/rf_q_o/rf_v_o take the head values.
  - retire_cnt_o+1.
- RUN, commit, kind 2 mispredicted:
  - rob_pop_o=1. Link write as above (suppressed when rd=0).
  - Next edge: flush_o=1, flush_pc_o=head_target_i, counter loaded with FLUSH_CYC-1, state→FLUSH, retire_cnt_o+1.
- RUN, commit, kind 1:
  - No pop. Next edge: st_req_o=1, st_rob_o=head_id_i, state→ST_WAIT.
- ST_WAIT:
  - st_req_o holds high until en & st_ack_i.
  - In that cycle rob_pop_o=1. Next edge: st_req_o=0, retire_cnt_o+1, state→RUN. No RF write.
  - head_* is ignored in this state.
- FLUSH:
  - rob_pop_o=0, no commits.
  - Counter decrements each enabled cycle. At 0: next edge flush_o=0, state→RUN.
- rd=0 never asserts rf_en_o, but the instruction still pops and counts.
- rob_pop_o is never asserted when en=0 or rst=1.
- en=0: state, counter, st_req_o, st_rob_o, flush_o, flush_pc_o and retire_cnt_o hold; rf_en_o clears to 0 at the edge.
- rst (also mid-store or mid-flush): all outputs 0, counter 0, state RUN, next edge. Any pending store is abandoned.

## Timing
- Reset values: every registered output is 0. rob_pop_o=0 while rst=1.
- Decision in cycle N (combinational pop); RF write visible in cycle N+1.
- Throughput: one reg/branch commit per cycle, back-to-back.
- Store: request at N+1, ack at cycle M ≥ N+1 gives pop in M and st_req_o=0 at M+1. Minimum 2 cycles per store.
- Mispredict at N: flush_o high in cycles N+1 .. N+FLUSH_CYC; first new commit possible in cycle N+FLUSH_CYC+1.
- rf_en_o is a one-cycle pulse per commit. It stays high across consecutive commit cycles.
- retire_cnt_o wraps 0xFFFFFFFF→0.

## Test plan
- After reset: head reg-write rd=5, v=0x1234, id=3, ready, 3 consecutive cycles with different ids → rob_pop_o high in 3 consecutive cycles; rf_en_o high in the 3 following cycles with rf_rd_o=5, rf_q_o matching each id; retire_cnt_o=3.
- rd=0, v=0xFFFF → pop=1, rf_en_o stays 0, retire_cnt_o increments.
- Store head id=7, st_ack_i after 3 cycles → st_req_o=1 with st_rob_o=7 for 3 cycles; pop in the ack cycle only; st_req_o=0 the next cycle; no rf_en_o.
- Mispredicted jump rd=1, v=0x100, target=0x2000, FLUSH_CYC=2 → pop, rf write x1=0x100, flush_o high exactly 2 cycles with flush_pc_o=0x2000; a ready head during the flush is not popped until the following cycle.
- en=0 for 2 cycles mid-ST_WAIT with st_ack_i=1 → no pop, st_req_o held; pop once en returns.
- rst pulsed during FLUSH and during ST_WAIT → next cycle all outputs 0 and state RUN; a ready head then commits normally.
